// File: rtl/quad_eval_arbiter.sv
// quad_eval_arbiter: round-robin arbiter feeding an external quadratic datapath,
// tracking in-flight operations with a tag pipeline and a drain/halt control.
module quad_eval_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] req_a,
    input  logic [31:0] req_x,
    input  logic [31:0] req_b,
    input  logic [31:0] req_c,
    input  logic        drain,
    output logic [3:0]  gnt,
    output logic [7:0]  dp_a,
    output logic [7:0]  dp_x,
    output logic [7:0]  dp_b,
    output logic [7:0]  dp_c,
    input  logic [15:0] dp_result,
    output logic        rsp_valid,
    output logic [1:0]  rsp_id,
    output logic [15:0] rsp_data,
    output logic        idle
);
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
    state_t state;
    logic [1:0] ptr, win, gid;
    logic hit, issue;
    logic [LATENCY-1:0] tv;
    logic [1:0] tid [LATENCY];
    logic [2:0] cnt, cnt_nxt;
    // scan from ptr+3 down to ptr so the last hit is the first in rotation order
    always_comb begin
        hit = 1'b0;
        win = ptr;
        for (int j = 3; j >= 0; j--) begin
            if (req[ptr + 2'(j)]) begin
                hit = 1'b1;
                win = ptr + 2'(j);
            end
        end
    end
    assign issue   = hit && state == RUN && !drain;
    assign cnt_nxt = cnt + 3'(|gnt) - 3'(rsp_valid);
    assign idle    = cnt == '0 && gnt == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ptr       <= '0;
            gid       <= '0;
            gnt       <= '0;
            dp_a      <= '0;
            dp_x      <= '0;
            dp_b      <= '0;
            dp_c      <= '0;
            tv        <= '0;
            for (int j = 0; j < LATENCY; j++) tid[j] <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            cnt       <= '0;
        end else begin
            gnt  <= issue ? 4'b0001 << win : 4'b0000;
            dp_a <= issue ? req_a[{win, 3'b000} +: 8] : 8'h00;
            dp_x <= issue ? req_x[{win, 3'b000} +: 8] : 8'h00;
            dp_b <= issue ? req_b[{win, 3'b000} +: 8] : 8'h00;
            dp_c <= issue ? req_c[{win, 3'b000} +: 8] : 8'h00;
            if (issue) begin
                ptr <= win + 2'd1;
                gid <= win;
            end
            tv[0]  <= |gnt;
            tid[0] <= gid;
            for (int j = 1; j < LATENCY; j++) begin
                tv[j]  <= tv[j-1];
                tid[j] <= tid[j-1];
            end
            rsp_valid <= tv[LATENCY-1];
            if (tv[LATENCY-1]) begin
                rsp_id   <= tid[LATENCY-1];
                rsp_data <= dp_result;
            end
            cnt   <= cnt_nxt;
            state <= drain ? (cnt_nxt != '0 ? DRAIN : HALT) : RUN;
        end
    end
endmodule

// File: tb/tb_quad_eval_arbiter.sv
// tb_quad_eval_arbiter: randomized and directed stimulus against a round-robin
// reference model with a response scoreboard and an external datapath model.
module tb_quad_eval_arbiter;
    localparam int L = 2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_a = '0, req_x = '0, req_b = '0, req_c = '0;
    logic        drain = 1'b0;
    logic [3:0]  gnt;
    logic [7:0]  dp_a, dp_x, dp_b, dp_c;
    logic [15:0] dp_result;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        idle;

    quad_eval_arbiter #(.LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .req_a(req_a), .req_x(req_x), .req_b(req_b), .req_c(req_c),
        .drain(drain), .gnt(gnt),
        .dp_a(dp_a), .dp_x(dp_x), .dp_b(dp_b), .dp_c(dp_c),
        .dp_result(dp_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] quad(input int a, input int x, input int b, input int c);
        return 16'((a * x + b) * x + c);
    endfunction

    // external datapath: result appears L cycles after the operands
    logic [15:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= quad(dp_a, dp_x, dp_b, dp_c);
        for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
    end
    assign dp_result = pipe[L-1];

    typedef struct {int id; logic [15:0] data; int due;} exp_t;
    exp_t q[$];
    int cyc = 0, m_ptr, w, last_due, last_id;
    logic m_prev_drain, exp_idle;
    logic [3:0] exp_gnt;
    logic [7:0] exp_a, exp_x, exp_b, exp_c;
    logic [15:0] last_data;

    // reference model: grants are possible only when drain was low at this and the previous edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_prev_drain = 1'b0; q.delete();
            exp_gnt = '0; exp_a = '0; exp_x = '0; exp_b = '0; exp_c = '0;
            exp_idle = 1'b1; last_due = -1; last_id = 0; last_data = '0;
        end else begin
            cyc++;
            exp_gnt = '0; exp_a = '0; exp_x = '0; exp_b = '0; exp_c = '0;
            w = -1;
            if (!drain && !m_prev_drain)
                for (int j = 0; j < 4; j++)
                    if (w < 0 && req[(m_ptr + j) % 4]) w = (m_ptr + j) % 4;
            if (w >= 0) begin
                exp_gnt = 4'(1 << w);
                exp_a = req_a[8*w +: 8]; exp_x = req_x[8*w +: 8];
                exp_b = req_b[8*w +: 8]; exp_c = req_c[8*w +: 8];
                m_ptr = (w + 1) % 4;
                last_due = cyc + L + 1;
                q.push_back('{w, quad(exp_a, exp_x, exp_b, exp_c), last_due});
            end
            m_prev_drain = drain;
            exp_idle = exp_gnt == '0 && cyc > last_due;
        end
    end

    exp_t e;
    always @(negedge clk) if (rst_n) begin
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("dp_a", 32'(dp_a), 32'(exp_a));
        chk("dp_x", 32'(dp_x), 32'(exp_x));
        chk("dp_b", 32'(dp_b), 32'(exp_b));
        chk("dp_c", 32'(dp_c), 32'(exp_c));
        chk("idle", 32'(idle), 32'(exp_idle));
        if (rsp_valid) begin
            if (q.size() == 0) chk("rsp_spurious", 32'(rsp_valid), 32'd0);
            else begin
                e = q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_cycle", cyc, e.due);
                last_id = e.id;
                last_data = e.data;
            end
        end else begin
            chk("rsp_id_hold", 32'(rsp_id), 32'(last_id));
            chk("rsp_data_hold", 32'(rsp_data), 32'(last_data));
            if (q.size() != 0 && q[0].due <= cyc) begin
                chk("rsp_missing", 32'(rsp_valid), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic d, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            req = r;
            drain = d;
        end
    endtask

    task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] x,
                            input logic [7:0] b, input logic [7:0] c);
        req_a[8*i +: 8] = a; req_x[8*i +: 8] = x;
        req_b[8*i +: 8] = b; req_c[8*i +: 8] = c;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_dp"}, {dp_a, dp_x, dp_b, dp_c}, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    initial begin
        #1;
        reset_checks("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_lane(0, 8'd2, 8'd3, 8'd4, 8'd5);
        drive(4'b0001, 1'b0, 1);
        drive(4'b0000, 1'b0, 6);
        for (int i = 0; i < 4; i++) set_lane(i, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        drive(4'b1111, 1'b0, 8);
        drive(4'b0000, 1'b0, 6);
        drive(4'b0100, 1'b0, 1);
        drive(4'b1011, 1'b0, 3);
        drive(4'b0000, 1'b0, 6);
        drive(4'b0011, 1'b0, 2);
        drive(4'b1111, 1'b1, 8);
        drive(4'b1111, 1'b0, 4);
        drive(4'b0000, 1'b0, 6);
        set_lane(3, 8'd255, 8'd255, 8'd255, 8'd0);
        drive(4'b1000, 1'b0, 1);
        drive(4'b0000, 1'b0, 6);
        set_lane(1, 8'd1, 8'd10, 8'd0, 8'd7);
        drive(4'b0010, 1'b0, 1);
        drive(4'b0000, 1'b0, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 reset_checks("midflight");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0000, 1'b0, 8);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            req = 4'($urandom);
            drain = $urandom_range(0, 9) == 0;
            req_a = $urandom(); req_x = $urandom(); req_b = $urandom(); req_c = $urandom();
        end
        drive(4'b0000, 1'b0, 10);
        chk("pending", q.size(), 32'd0);
        chk("final_idle", 32'(idle), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
